// File: rtl/parity_stream_ctrl_if.sv
// Word stream in, packet parity report out, as one bundle.
// The slave side is the controller; the master side is whoever drives words and takes reports.
interface parity_stream_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic             s_par;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] m_len;
  logic [CNT_W-1:0] m_err_cnt;
  logic             m_pkt_par;
  logic             m_ovf;

  modport slave (
    input  s_valid, s_data, s_par, s_last, m_ready,
    output s_ready, m_valid, m_len, m_err_cnt, m_pkt_par, m_ovf
  );

  modport master (
    output s_valid, s_data, s_par, s_last, m_ready,
    input  s_ready, m_valid, m_len, m_err_cnt, m_pkt_par, m_ovf
  );
endinterface

// File: rtl/parity_stream_ctrl.sv
// Packet parity checker: accumulates length, per-word odd-parity errors and packet parity,
// then holds a report until the consumer takes it.
module parity_stream_ctrl #(
  parameter int unsigned MAX_LEN = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  parity_stream_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ERR_SAT = '1;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_len, w_len_nxt;
  logic [CNT_W-1:0] r_err, w_err_nxt;
  logic             r_pkt_par, w_pkt_par_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_s_ready, r_m_valid;
  logic             w_xfer, w_word_xor, w_par_err, w_hit;

  assign w_xfer     = bus.s_valid & r_s_ready;
  assign w_word_xor = ^bus.s_data;
  // Word parity is the XNOR reduction, i.e. the inverse of the XOR reduction.
  assign w_par_err  = (bus.s_par != ~w_word_xor);

  // Next state and next accumulators; r_pkt_par holds the already-inverted accumulator.
  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_err_nxt     = r_err;
    w_pkt_par_nxt = r_pkt_par;
    w_ovf_nxt     = r_ovf;
    w_hit         = 1'b0;
    case (r_state)
      IDLE, RUN: begin
        if (w_xfer) begin
          if (r_state == IDLE) begin
            w_len_nxt     = CNT_W'(1);
            w_err_nxt     = CNT_W'(w_par_err);
            w_pkt_par_nxt = ~w_word_xor;
          end else begin
            w_len_nxt     = r_len + CNT_W'(1);
            w_err_nxt     = (w_par_err && (r_err != ERR_SAT)) ? r_err + CNT_W'(1) : r_err;
            w_pkt_par_nxt = r_pkt_par ^ w_word_xor;
          end
          w_hit       = (w_len_nxt == LEN_MAX);
          w_ovf_nxt   = w_hit & ~bus.s_last;
          w_state_nxt = (bus.s_last || w_hit) ? REPORT : RUN;
        end
      end
      REPORT: begin
        if (bus.m_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_err     <= '0;
      r_pkt_par <= 1'b1;
      r_ovf     <= 1'b0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_err     <= w_err_nxt;
      r_pkt_par <= w_pkt_par_nxt;
      r_ovf     <= w_ovf_nxt;
      r_s_ready <= (w_state_nxt != REPORT);
      r_m_valid <= (w_state_nxt == REPORT);
    end
  end

  assign bus.s_ready   = r_s_ready;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_len     = r_len;
  assign bus.m_err_cnt = r_err;
  assign bus.m_pkt_par = r_pkt_par;
  assign bus.m_ovf     = r_ovf;

endmodule

// File: tb/tb_parity_stream_ctrl.sv
// Directed bench for parity_stream_ctrl: default instance u0 and a MAX_LEN=4 instance u1.
module tb_parity_stream_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  parity_stream_ctrl_if #(.CNT_W(8)) b0 ();
  parity_stream_ctrl_if #(.CNT_W(8)) b1 ();

  parity_stream_ctrl u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  parity_stream_ctrl #(.MAX_LEN(4), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  // Packs {s_ready, m_valid, m_len, m_err_cnt, m_pkt_par, m_ovf} of one instance.
  function automatic logic [19:0] snap(input int u);
    if (u == 0) return {b0.s_ready, b0.m_valid, b0.m_len, b0.m_err_cnt, b0.m_pkt_par, b0.m_ovf};
    return {b1.s_ready, b1.m_valid, b1.m_len, b1.m_err_cnt, b1.m_pkt_par, b1.m_ovf};
  endfunction

  // Presents one word and returns just after the edge that accepted it.
  task automatic send(input int u, input logic [31:0] d, input logic p, input logic l);
    int   n = 0;
    logic rdy;
    if (u == 0) begin b0.s_valid = 1'b1; b0.s_data = d; b0.s_par = p; b0.s_last = l; end
    else        begin b1.s_valid = 1'b1; b1.s_data = d; b1.s_par = p; b1.s_last = l; end
    @(negedge clk);
    rdy = (u == 0) ? b0.s_ready : b1.s_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
      rdy = (u == 0) ? b0.s_ready : b1.s_ready;
    end
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout u%0d: s_ready=%0b required 1", u, rdy);
    end
    @(posedge clk); #1;
    if (u == 0) b0.s_valid = 1'b0; else b1.s_valid = 1'b0;
  endtask

  task automatic consume(input int u);
    if (u == 0) b0.m_ready = 1'b1; else b1.m_ready = 1'b1;
    @(posedge clk); #1;
    if (u == 0) b0.m_ready = 1'b0; else b1.m_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [19:0] exp;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    exp = {1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      if (snap(u) !== exp) begin
        n_fail++; $display("FAIL reset_values u%0d: got %05h required %05h", u, snap(u), exp);
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (b0.s_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge: got %0b required 0", b0.s_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({b0.s_ready, b1.s_ready} !== 2'b11) begin
      n_fail++; $display("FAIL ready_after_edge: got %02b required 11", {b0.s_ready, b1.s_ready});
    end
  endtask

  task automatic test_single;
    logic [19:0] exp;
    send(0, 32'h0000_0000, 1'b1, 1'b1);
    exp = {1'b0, 1'b1, 8'd1, 8'd0, 1'b1, 1'b0};
    n_cmp++;
    if (snap(0) !== exp) begin
      n_fail++; $display("FAIL single_word: got %05h required %05h", snap(0), exp);
    end
    consume(0);
  endtask

  task automatic test_two_words;
    logic [19:0] exp;
    send(0, 32'h0000_0001, 1'b0, 1'b0);
    send(0, 32'h0000_0003, 1'b0, 1'b1);
    exp = {1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0};
    n_cmp++;
    if (snap(0) !== exp) begin
      n_fail++; $display("FAIL two_words: got %05h required %05h", snap(0), exp);
    end
    consume(0);
  endtask

  task automatic test_hold;
    logic [19:0] exp;
    send(0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send(0, 32'h0000_0007, 1'b1, 1'b1);
    // A valid word waits at the input the whole time; it must not be taken in REPORT.
    b0.s_valid = 1'b1; b0.s_data = 32'h0000_0000; b0.s_par = 1'b1; b0.s_last = 1'b1;
    exp = {1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (snap(0) !== exp) begin
        n_fail++; $display("FAIL hold_cycle%0d: got %05h required %05h", i, snap(0), exp);
      end
      @(posedge clk); #1;
    end
    b0.s_valid = 1'b0;
    consume(0);
    exp = {1'b1, 1'b0, 8'd2, 8'd1, 1'b0, 1'b0};
    n_cmp++;
    if (snap(0) !== exp) begin
      n_fail++; $display("FAIL hold_consumed: got %05h required %05h", snap(0), exp);
    end
  endtask

  task automatic test_gaps;
    logic [31:0] wd [6];
    logic [19:0] exp;
    wd = '{32'h1, 32'h3, 32'h7, 32'hF, 32'h10, 32'hFF};
    exp = {1'b0, 1'b1, 8'd6, 8'd3, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) send(0, wd[i], 1'b1, (i == 5));
    n_cmp++;
    if (snap(0) !== exp) begin
      n_fail++; $display("FAIL gapfree_pkt: got %05h required %05h", snap(0), exp);
    end
    consume(0);
    for (int i = 0; i < 6; i++) begin
      send(0, wd[i], 1'b1, (i == 5));
      if (i < 5) begin
        b0.s_data = 32'hDEAD_BEEF; b0.s_par = 1'b0; b0.s_last = 1'b1;
        @(posedge clk); #1;
      end
    end
    n_cmp++;
    if (snap(0) !== exp) begin
      n_fail++; $display("FAIL gapped_pkt: got %05h required %05h", snap(0), exp);
    end
    consume(0);
  endtask

  task automatic test_reset_mid;
    logic [19:0] exp;
    for (int i = 0; i < 3; i++) send(0, 32'h0000_0001, 1'b1, 1'b0);
    exp = {1'b1, 1'b0, 8'd3, 8'd3, 1'b0, 1'b0};
    n_cmp++;
    if (snap(0) !== exp) begin
      n_fail++; $display("FAIL mid_pkt_state: got %05h required %05h", snap(0), exp);
    end
    #2 rst_n = 1'b0;
    #1;
    exp = {1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
    n_cmp++;
    if (snap(0) !== exp) begin
      n_fail++; $display("FAIL mid_pkt_reset: got %05h required %05h", snap(0), exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 32'h0000_0000, 1'b1, 1'b1);
    exp = {1'b0, 1'b1, 8'd1, 8'd0, 1'b1, 1'b0};
    n_cmp++;
    if (snap(0) !== exp) begin
      n_fail++; $display("FAIL post_reset_pkt: got %05h required %05h", snap(0), exp);
    end
    consume(0);
  endtask

  task automatic test_overflow;
    logic [19:0] exp;
    send(1, 32'h1, 1'b0, 1'b0);
    send(1, 32'h2, 1'b0, 1'b0);
    send(1, 32'h4, 1'b0, 1'b0);
    send(1, 32'h8, 1'b0, 1'b0);
    exp = {1'b0, 1'b1, 8'd4, 8'd0, 1'b1, 1'b1};
    n_cmp++;
    if (snap(1) !== exp) begin
      n_fail++; $display("FAIL ovf_report: got %05h required %05h", snap(1), exp);
    end
    b1.s_valid = 1'b1; b1.s_data = 32'h3; b1.s_par = 1'b0; b1.s_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (snap(1) !== exp) begin
        n_fail++; $display("FAIL ovf_holdoff%0d: got %05h required %05h", i, snap(1), exp);
      end
    end
    @(posedge clk); #1;
    consume(1);
    @(posedge clk); #1;
    b1.s_valid = 1'b0;
    exp = {1'b1, 1'b0, 8'd1, 8'd1, 1'b1, 1'b0};
    n_cmp++;
    if (snap(1) !== exp) begin
      n_fail++; $display("FAIL ovf_fifth_word: got %05h required %05h", snap(1), exp);
    end
    send(1, 32'h0, 1'b1, 1'b1);
    exp = {1'b0, 1'b1, 8'd2, 8'd1, 1'b1, 1'b0};
    n_cmp++;
    if (snap(1) !== exp) begin
      n_fail++; $display("FAIL ovf_next_pkt: got %05h required %05h", snap(1), exp);
    end
    consume(1);
  endtask

  initial begin
    b0.s_valid = 1'b0; b0.s_data = '0; b0.s_par = 1'b0; b0.s_last = 1'b0; b0.m_ready = 1'b0;
    b1.s_valid = 1'b0; b1.s_data = '0; b1.s_par = 1'b0; b1.s_last = 1'b0; b1.m_ready = 1'b0;
    test_reset();
    test_single();
    test_two_words();
    test_hold();
    test_gaps();
    test_reset_mid();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
